// File: rtl/axi2per_pkg.sv
// axi2per_pkg: shared burst constants, FSM states and size clamp for the axi2per AR path.
package axi2per_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam int PER_DATA_BYTES = 4;

  typedef enum logic {IDLE, BURST} state_e;

  // The peripheral is 32 bits wide, so wider AXI beats collapse to word beats.
  function automatic logic [1:0] eff_size(input logic [2:0] size);
    return size > 3'd2 ? 2'd2 : size[1:0];
  endfunction
endpackage

// File: rtl/axi2per_burst_addr_gen.sv
// axi2per_burst_addr_gen: next beat address and byte enables for FIXED/INCR/WRAP bursts.
// WRAP handling is compiled only with AXI2PER_WRAP_BURST_EN; otherwise WRAP behaves as INCR.
module axi2per_burst_addr_gen
  import axi2per_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [2:0]                size_i,
  input  logic [7:0]                len_i,
  input  logic [1:0]                burst_i,
  output logic [ADDR_WIDTH-1:0]     next_addr_o,
  output logic [PER_DATA_BYTES-1:0] be_o
);
  logic [1:0]            es;
  logic [ADDR_WIDTH-1:0] inc;
  logic [ADDR_WIDTH-1:0] incr_addr;

  assign es        = eff_size(size_i);
  assign inc       = ADDR_WIDTH'(1) << es;
  assign incr_addr = addr_i + inc;
  assign be_o      = es == 2'd0 ? 4'b0001 << addr_i[1:0] :
                     es == 2'd1 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;

`ifdef AXI2PER_WRAP_BURST_EN
  logic                  wrap;
  logic [ADDR_WIDTH-1:0] mask;

  // Only 2/4/8/16-beat wraps are legal; anything else falls back to INCR.
  assign wrap = burst_i == BURST_WRAP &&
                (len_i == 8'd1 || len_i == 8'd3 || len_i == 8'd7 || len_i == 8'd15);
  assign mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << es) - ADDR_WIDTH'(1);
  assign next_addr_o = burst_i == BURST_FIXED ? addr_i :
                       wrap ? (addr_i & ~mask) | (incr_addr & mask) : incr_addr;
`else
  logic unused_len;

  assign unused_len  = ^len_i;
  assign next_addr_o = burst_i == BURST_FIXED ? addr_i : incr_addr;
`endif
endmodule

// File: rtl/axi2per_ar_burst_gen.sv
// axi2per_ar_burst_gen: expands buffered AXI AR bursts into single-beat peripheral reads.
// Optional WRAP support via AXI2PER_WRAP_BURST_EN (see axi2per_burst_addr_gen).
module axi2per_ar_burst_gen
  import axi2per_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ar_valid_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [1:0]            ar_burst_i,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [USER_WIDTH-1:0] ar_user_i,
  output logic                  ar_ready_o,
  output logic                  per_req_o,
  output logic [ADDR_WIDTH-1:0] per_add_o,
  output logic                  per_we_o,
  output logic [3:0]            per_be_o,
  input  logic                  per_gnt_i,
  output logic                  trans_valid_o,
  output logic [ID_WIDTH-1:0]   trans_id_o,
  output logic [USER_WIDTH-1:0] trans_user_o,
  output logic                  trans_last_o,
  input  logic                  trans_ready_i
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr;
  logic [7:0]            len_q, len_d, cnt_q, cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic [3:0]            be;
  logic                  beat, last;

  axi2per_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr),
    .be_o        (be)
  );

  assign last = cnt_q == len_q;
  assign beat = state_q == BURST && trans_ready_i && per_gnt_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == IDLE ? (ar_valid_i ? BURST : IDLE) : (beat && last ? IDLE : BURST);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      user_q  <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      user_q  <= user_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    id_d    = id_q;
    user_d  = user_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && ar_valid_i) begin
      addr_d  = ar_addr_i;
      len_d   = ar_len_i;
      size_d  = ar_size_i;
      burst_d = ar_burst_i;
      id_d    = ar_id_i;
      user_d  = ar_user_i;
      cnt_d   = '0;
    end else if (beat) begin
      addr_d = next_addr;
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_comb begin
    ar_ready_o    = state_q == IDLE;
    per_req_o     = state_q == BURST && trans_ready_i;
    per_be_o      = state_q == BURST ? be : 4'b0000;
    trans_valid_o = beat;
    trans_last_o  = state_q == BURST && last;
  end

  assign per_add_o    = addr_q;
  assign per_we_o     = 1'b0;
  assign trans_id_o   = id_q;
  assign trans_user_o = user_q;
endmodule

// File: tb/tb_axi2per_ar_burst_gen.sv
// tb_axi2per_ar_burst_gen: directed bench with a closed-form burst model checked every cycle.
module tb_axi2per_ar_burst_gen;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ar_valid_i;
  logic [31:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic [3:0]  ar_id_i;
  logic [5:0]  ar_user_i;
  logic        ar_ready_o, per_req_o, per_we_o, per_gnt_i;
  logic [31:0] per_add_o;
  logic [3:0]  per_be_o;
  logic        trans_valid_o, trans_last_o, trans_ready_i;
  logic [3:0]  trans_id_o;
  logic [5:0]  trans_user_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] log_addr[$];
  logic [3:0]  log_be[$];
  logic        log_last[$];
  logic [3:0]  log_id[$];
  int          log_cyc[$];

  bit          m_ok = 0, m_busy = 0;
  int          m_k, m_len;
  logic [31:0] m_a0;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic [3:0]  m_id;
  logic [5:0]  m_user;

  axi2per_ar_burst_gen dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ar_valid_i(ar_valid_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
    .ar_user_i(ar_user_i), .ar_ready_o(ar_ready_o), .per_req_o(per_req_o),
    .per_add_o(per_add_o), .per_we_o(per_we_o), .per_be_o(per_be_o), .per_gnt_i(per_gnt_i),
    .trans_valid_o(trans_valid_o), .trans_id_o(trans_id_o), .trans_user_o(trans_user_o),
    .trans_last_o(trans_last_o), .trans_ready_i(trans_ready_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat k of a burst, computed directly from the start address.
  function automatic logic [31:0] exp_addr(input logic [31:0] a0, input int k, input logic [2:0] size,
                                           input int len, input logic [1:0] burst);
    int s = size > 3'd2 ? 2 : int'(size);
    logic [31:0] off = 32'(k) << s;
    logic [31:0] mask = (32'(len + 1) << s) - 32'd1;
    bit wrap_ok = 0;
`ifdef AXI2PER_WRAP_BURST_EN
    wrap_ok = burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15);
`endif
    if (burst == 2'd0) return a0;
    if (wrap_ok) return (a0 & ~mask) | ((a0 + off) & mask);
    return a0 + off;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] size);
    if (size == 3'd0) return 4'(1 << a[1:0]);
    if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_busy = 0;
      m_ok = 1;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (ar_valid_i) begin
          m_a0 = ar_addr_i; m_len = int'(ar_len_i); m_size = ar_size_i;
          m_burst = ar_burst_i; m_id = ar_id_i; m_user = ar_user_i;
          m_busy = 1; m_k = 0;
        end
      end else if (trans_ready_i && per_gnt_i) begin
        if (m_k == m_len) m_busy = 0;
        else m_k++;
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_ok && rst_ni) begin
      logic [31:0] ea;
      bit xfer;
      xfer = m_busy && trans_ready_i && per_gnt_i;
      chk("ar_ready", 32'(ar_ready_o), 32'(!m_busy));
      chk("per_req", 32'(per_req_o), 32'(m_busy && trans_ready_i));
      chk("trans_valid", 32'(trans_valid_o), 32'(xfer));
      chk("per_we", 32'(per_we_o), 32'd0);
      if (m_busy) begin
        ea = exp_addr(m_a0, m_k, m_size, m_len, m_burst);
        chk("per_add", per_add_o, ea);
        chk("per_be", 32'(per_be_o), 32'(exp_be(ea, m_size)));
      end
      if (xfer) begin
        chk("trans_last", 32'(trans_last_o), 32'(m_k == m_len));
        chk("trans_id", 32'(trans_id_o), 32'(m_id));
        chk("trans_user", 32'(trans_user_o), 32'(m_user));
      end
      if (trans_valid_o) begin
        log_addr.push_back(per_add_o); log_be.push_back(per_be_o);
        log_last.push_back(trans_last_o); log_id.push_back(trans_id_o);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_log();
    log_addr.delete(); log_be.delete(); log_last.delete(); log_id.delete(); log_cyc.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ar_ready_o && n < 1000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL wait_idle: ar_ready still %0b after %0d cycles, required 1", ar_ready_o, n);
    end
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input logic [5:0] user);
    wait_idle();
    ar_valid_i = 1; ar_addr_i = a; ar_len_i = len; ar_size_i = size;
    ar_burst_i = burst; ar_id_i = id; ar_user_i = user;
    @(posedge clk_i); #1;
    ar_valid_i = 0;
  endtask

  task automatic chk_beat(input string name, input int i, input logic [31:0] a,
                          input logic [3:0] be, input logic last);
    chk({name, "_addr"}, log_addr[i], a);
    chk({name, "_be"}, 32'(log_be[i]), 32'(be));
    chk({name, "_last"}, 32'(log_last[i]), 32'(last));
  endtask

  initial begin
    rst_ni = 0; ar_valid_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0;
    ar_burst_i = 0; ar_id_i = 0; ar_user_i = 0; per_gnt_i = 1; trans_ready_i = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ar_ready", 32'(ar_ready_o), 32'd1);
    chk("rst_per_req", 32'(per_req_o), 32'd0);
    chk("rst_per_add", per_add_o, 32'd0);
    chk("rst_per_be", 32'(per_be_o), 32'd0);
    chk("rst_trans_valid", 32'(trans_valid_o), 32'd0);
    chk("rst_trans_last", 32'(trans_last_o), 32'd0);
    chk("rst_trans_id", 32'(trans_id_o), 32'd0);
    chk("rst_trans_user", 32'(trans_user_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1;

    clear_log();
    send_ar(32'h1000, 8'd3, 3'd2, 2'd1, 4'h3, 6'h11);
    wait_idle();
    chk("incr_beats", log_addr.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk_beat("incr", i, 32'h1000 + 32'(4 * i), 4'hF, i == 3);
    chk("incr_ready_lat", cyc, log_cyc[3] + 1);

    clear_log();
    send_ar(32'h2008, 8'd3, 3'd2, 2'd2, 4'h1, 6'h01);
    wait_idle();
    chk("wrap_beats", log_addr.size(), 32'd4);
`ifdef AXI2PER_WRAP_BURST_EN
    chk_beat("wrap0", 0, 32'h2008, 4'hF, 0); chk_beat("wrap1", 1, 32'h200C, 4'hF, 0);
    chk_beat("wrap2", 2, 32'h2000, 4'hF, 0); chk_beat("wrap3", 3, 32'h2004, 4'hF, 1);
`else
    chk_beat("wrap0", 0, 32'h2008, 4'hF, 0); chk_beat("wrap1", 1, 32'h200C, 4'hF, 0);
    chk_beat("wrap2", 2, 32'h2010, 4'hF, 0); chk_beat("wrap3", 3, 32'h2014, 4'hF, 1);
`endif

    clear_log();
    send_ar(32'h3001, 8'd2, 3'd0, 2'd0, 4'hA, 6'h2A);
    wait_idle();
    chk("fixed_beats", log_addr.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk_beat("fixed", i, 32'h3001, 4'b0010, i == 2);
      chk("fixed_id", 32'(log_id[i]), 32'hA);
    end

    clear_log();
    per_gnt_i = 0;
    send_ar(32'h500, 8'd1, 3'd2, 2'd1, 4'h5, 6'h05);
    repeat (3) begin @(posedge clk_i); #1; end
    per_gnt_i = 1;
    @(posedge clk_i); #1;
    trans_ready_i = 0;
    repeat (2) begin @(posedge clk_i); #1; end
    trans_ready_i = 1;
    wait_idle();
    chk("stall_beats", log_addr.size(), 32'd2);
    chk_beat("stall0", 0, 32'h500, 4'hF, 0);
    chk_beat("stall1", 1, 32'h504, 4'hF, 1);

    send_ar(32'h100, 8'd7, 3'd2, 2'd1, 4'h7, 6'h07);
    repeat (2) begin @(posedge clk_i); #1; end
    rst_ni = 0;
    @(posedge clk_i); #1;
    rst_ni = 1;
    @(negedge clk_i);
    chk("midrst_per_req", 32'(per_req_o), 32'd0);
    chk("midrst_ar_ready", 32'(ar_ready_o), 32'd1);
    chk("midrst_trans_valid", 32'(trans_valid_o), 32'd0);
    @(posedge clk_i); #1;
    clear_log();
    send_ar(32'h40, 8'd0, 3'd2, 2'd1, 4'h2, 6'h02);
    wait_idle();
    chk("single_beats", log_addr.size(), 32'd1);
    chk_beat("single", 0, 32'h40, 4'hF, 1);

    clear_log();
    wait_idle();
    ar_valid_i = 1; ar_addr_i = 32'h600; ar_len_i = 8'd1; ar_size_i = 3'd3;
    ar_burst_i = 2'd1; ar_id_i = 4'h6; ar_user_i = 6'h06;
    @(posedge clk_i); #1;
    ar_addr_i = 32'h700; ar_len_i = 8'd1; ar_size_i = 3'd1; ar_burst_i = 2'd3; ar_id_i = 4'h9;
    begin
      int n = 0;
      while (!ar_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
      if (n >= 50) begin
        checks++; errors++;
        $display("FAIL b2b_wait: ar_ready still 0 after %0d cycles, required 1", n);
      end
    end
    @(posedge clk_i); #1;
    ar_valid_i = 0;
    wait_idle();
    chk("b2b_beats", log_addr.size(), 32'd4);
    chk_beat("b2b0", 0, 32'h600, 4'hF, 0);
    chk_beat("b2b1", 1, 32'h604, 4'hF, 1);
    chk_beat("b2b2", 2, 32'h700, 4'b0011, 0);
    chk_beat("b2b3", 3, 32'h702, 4'b1100, 1);
    chk("b2b_gap", log_cyc[2] - log_cyc[1], 32'd2);
    chk("b2b_id", 32'(log_id[2]), 32'h9);

    clear_log();
    send_ar(32'hFFFF_FF00, 8'd255, 3'd2, 2'd1, 4'hF, 6'h3F);
    wait_idle();
    chk("long_beats", log_addr.size(), 32'd256);
    chk_beat("long254", 254, 32'h0000_02F8, 4'hF, 0);
    chk_beat("long255", 255, 32'h0000_02FC, 4'hF, 1);

    repeat (2) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
